// File: rtl/dmem_pkg.sv
// Shared definitions for data_memory and its arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 32;
  localparam int unsigned DMEM_DATA_W = 32;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } requester_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side bus bundle for data_mem_arbiter.
interface data_mem_arbiter_if import dmem_pkg::*; #(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);
  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_address;
  logic [DATA_W-1:0] dbg_write_data;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rsp_valid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  cpu_req, cpu_write, cpu_address, cpu_write_data,
    output cpu_gnt, cpu_stall, cpu_rsp_valid, cpu_rdata,
    input  dbg_req, dbg_write, dbg_address, dbg_write_data, dbg_lock,
    output dbg_gnt, dbg_rsp_valid, dbg_rdata,
    output mem_write, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output cpu_req, cpu_write, cpu_address, cpu_write_data,
    input  cpu_gnt, cpu_stall, cpu_rsp_valid, cpu_rdata,
    output dbg_req, dbg_write, dbg_address, dbg_write_data, dbg_lock,
    input  dbg_gnt, dbg_rsp_valid, dbg_rdata,
    input  mem_write, mem_address, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/rr_lock_picker.sv
// Round-robin grant between cpu and dbg with a bounded dbg burst lock.
module rr_lock_picker import dmem_pkg::*; #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_cpu_req,
  input  logic i_dbg_req,
  input  logic i_dbg_lock,
  output logic o_cpu_gnt,
  output logic o_dbg_gnt
);

  localparam logic [7:0] LockMax = 8'(MAX_LOCK);

  requester_e r_last_gnt, w_last_gnt_d;
  logic [7:0] r_lock_cnt, w_lock_cnt_d;

  always_comb begin
    o_cpu_gnt = 1'b0;
    o_dbg_gnt = 1'b0;
    if (reset_n) begin
      if (i_cpu_req && i_dbg_req) begin
        if (r_lock_cnt == LockMax) begin
          o_cpu_gnt = 1'b1;
        end else if (i_dbg_lock) begin
          o_dbg_gnt = 1'b1;
        end else if (r_last_gnt == REQ_DBG) begin
          o_cpu_gnt = 1'b1;
        end else begin
          o_dbg_gnt = 1'b1;
        end
      end else begin
        o_cpu_gnt = i_cpu_req;
        o_dbg_gnt = i_dbg_req;
      end
    end
  end

  always_comb begin
    w_last_gnt_d = r_last_gnt;
    if (o_cpu_gnt) begin
      w_last_gnt_d = REQ_CPU;
    end else if (o_dbg_gnt) begin
      w_last_gnt_d = REQ_DBG;
    end

    // Only dbg grants that actually starve a waiting cpu count toward the lock bound.
    w_lock_cnt_d = r_lock_cnt;
    if (o_cpu_gnt || !i_dbg_lock) begin
      w_lock_cnt_d = 8'd0;
    end else if (o_dbg_gnt && i_cpu_req && (r_lock_cnt != LockMax)) begin
      w_lock_cnt_d = r_lock_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= REQ_DBG;
      r_lock_cnt <= 8'd0;
    end else begin
      r_last_gnt <= w_last_gnt_d;
      r_lock_cnt <= w_lock_cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates single-port data_memory between the MEM stage and the debug loader.
// Optional misaligned-access trap: define DMEM_ARB_ALIGN_CHECK_EN.
module data_mem_arbiter import dmem_pkg::*; #(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input logic clk,
  input logic reset_n,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic err_misaligned,
`endif
  data_mem_arbiter_if.slave bus
);

  logic              w_cpu_gnt;
  logic              w_dbg_gnt;
  logic              w_write;
  logic [ADDR_W-1:0] w_address;
  logic [DATA_W-1:0] w_write_data;
  logic              w_perform;

  logic              r_cpu_rsp_valid;
  logic              r_dbg_rsp_valid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  rr_lock_picker #(
    .MAX_LOCK (MAX_LOCK)
  ) u_picker (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_cpu_req  (bus.cpu_req),
    .i_dbg_req  (bus.dbg_req),
    .i_dbg_lock (bus.dbg_lock),
    .o_cpu_gnt  (w_cpu_gnt),
    .o_dbg_gnt  (w_dbg_gnt)
  );

  always_comb begin
    w_write      = 1'b0;
    w_address    = '0;
    w_write_data = '0;
    if (w_cpu_gnt) begin
      w_write      = bus.cpu_write;
      w_address    = bus.cpu_address;
      w_write_data = bus.cpu_write_data;
    end else if (w_dbg_gnt) begin
      w_write      = bus.dbg_write;
      w_address    = bus.dbg_address;
      w_write_data = bus.dbg_write_data;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic r_err_misaligned;
  logic w_misaligned;

  assign w_misaligned   = (w_cpu_gnt || w_dbg_gnt) && (w_address[1:0] != 2'b00);
  assign w_perform      = !w_misaligned;
  assign err_misaligned = r_err_misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_misaligned <= 1'b0;
    end else if (w_misaligned) begin
      r_err_misaligned <= 1'b1;
    end
  end
`else
  assign w_perform = 1'b1;
`endif

  assign bus.mem_write      = w_write && w_perform;
  assign bus.mem_address    = w_address;
  assign bus.mem_write_data = w_write_data;

  assign bus.cpu_gnt       = w_cpu_gnt;
  assign bus.dbg_gnt       = w_dbg_gnt;
  assign bus.cpu_stall     = bus.cpu_req && !w_cpu_gnt;
  assign bus.cpu_rsp_valid = r_cpu_rsp_valid;
  assign bus.dbg_rsp_valid = r_dbg_rsp_valid;
  assign bus.cpu_rdata     = r_cpu_rdata;
  assign bus.dbg_rdata     = r_dbg_rdata;

  // Read data is captured on the granting edge; the loser's rdata is left untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rsp_valid <= 1'b0;
      r_dbg_rsp_valid <= 1'b0;
      r_cpu_rdata     <= '0;
      r_dbg_rdata     <= '0;
    end else begin
      r_cpu_rsp_valid <= w_cpu_gnt && !w_write && w_perform;
      r_dbg_rsp_valid <= w_dbg_gnt && !w_write && w_perform;
      if (w_cpu_gnt && !w_write && w_perform) begin
        r_cpu_rdata <= bus.mem_read_data;
      end
      if (w_dbg_gnt && !w_write && w_perform) begin
        r_dbg_rdata <= bus.mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural data_memory.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err;
`endif

  data_mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_LOCK (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    .err_misaligned (err),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256] = '{default: 32'h0};
  assign bus.mem_read_data = mem[bus.mem_address[7:0]];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_write = wr; bus.cpu_address = a; bus.cpu_write_data = d;
  endtask

  task automatic drive_dbg(input logic req, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic lock);
    bus.dbg_req = req; bus.dbg_write = wr; bus.dbg_address = a; bus.dbg_write_data = d;
    bus.dbg_lock = lock;
  endtask

  task automatic idle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive_cpu(1'b1, 1'b1, 32'd20, 32'h12345678);
    drive_dbg(1'b1, 1'b0, 32'd12, 32'h0, 1'b0);
    #2;
    total++;
    if (bus.cpu_gnt !== 1'b0 || bus.dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL reset_gnt got=%b%b exp=00", bus.cpu_gnt, bus.dbg_gnt);
    end
    total++;
    if (bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write);
    end
    total++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.dbg_rsp_valid !== 1'b0 ||
        bus.cpu_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rsp got=%b%b %h %h exp=00 0 0", bus.cpu_rsp_valid,
                      bus.dbg_rsp_valid, bus.cpu_rdata, bus.dbg_rdata);
    end
    tick();
    total++;
    if (mem[20] !== 32'h0) begin
      bad++; $display("FAIL reset_no_write got=%h exp=0", mem[20]);
    end
    idle();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write_read();
    drive_cpu(1'b1, 1'b1, 32'd20, 32'hDEADBEEF);
    #2;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.mem_write !== 1'b1 ||
        bus.mem_address !== 32'd20) begin
      bad++; $display("FAIL cpu_write gnt=%b stall=%b we=%b addr=%0d exp=1 0 1 20",
                      bus.cpu_gnt, bus.cpu_stall, bus.mem_write, bus.mem_address);
    end
    tick();
    drive_cpu(1'b1, 1'b0, 32'd20, 32'h0);
    #2;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL cpu_read_gnt got=%b we=%b exp=1 0", bus.cpu_gnt, bus.mem_write);
    end
    tick();
    idle();
    total++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF ||
        bus.dbg_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL cpu_read_rsp got=%b %h exp=1 deadbeef", bus.cpu_rsp_valid,
                      bus.cpu_rdata);
    end
    tick();
    total++;
    if (bus.cpu_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL cpu_rsp_one_cycle got=%b exp=0", bus.cpu_rsp_valid);
    end
  endtask

  task automatic test_raw();
    drive_dbg(1'b1, 1'b1, 32'd12, 32'd5, 1'b0);
    #2;
    total++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_write !== 1'b1) begin
      bad++; $display("FAIL raw_dbg_write got=%b we=%b exp=1 1", bus.dbg_gnt, bus.mem_write);
    end
    tick();
    idle();
    drive_cpu(1'b1, 1'b0, 32'd12, 32'h0);
    total++;
    if (bus.dbg_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL raw_write_no_rsp got=%b exp=0", bus.dbg_rsp_valid);
    end
    tick();
    idle();
    total++;
    if (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rdata !== 32'd5) begin
      bad++; $display("FAIL raw_read got=%b %h exp=1 5", bus.cpu_rsp_valid, bus.cpu_rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    drive_cpu(1'b1, 1'b0, 32'd20, 32'h0);
    drive_dbg(1'b1, 1'b0, 32'd12, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic exp_cpu;
      exp_cpu = (i % 2 == 0);
      #2;
      total++;
      if (bus.cpu_gnt !== exp_cpu || bus.dbg_gnt !== !exp_cpu || bus.cpu_stall !== !exp_cpu)
      begin
        bad++; $display("FAIL alt_gnt[%0d] got=%b%b stall=%b exp_cpu=%b", i, bus.cpu_gnt,
                        bus.dbg_gnt, bus.cpu_stall, exp_cpu);
      end
      tick();
      total++;
      if (exp_cpu ? (bus.cpu_rsp_valid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF ||
                     bus.dbg_rsp_valid !== 1'b0)
                  : (bus.dbg_rsp_valid !== 1'b1 || bus.dbg_rdata !== 32'd5 ||
                     bus.cpu_rsp_valid !== 1'b0)) begin
        bad++; $display("FAIL alt_rsp[%0d] got=%b%b %h %h exp_cpu=%b", i, bus.cpu_rsp_valid,
                        bus.dbg_rsp_valid, bus.cpu_rdata, bus.dbg_rdata, exp_cpu);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_lock();
    drive_cpu(1'b1, 1'b0, 32'd20, 32'h0);
    drive_dbg(1'b1, 1'b0, 32'd12, 32'h0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      logic exp_cpu;
      exp_cpu = (i % 9 == 8);
      #2;
      total++;
      if (bus.cpu_gnt !== exp_cpu || bus.dbg_gnt !== !exp_cpu) begin
        bad++; $display("FAIL lock_gnt[%0d] got=%b%b exp_cpu=%b", i, bus.cpu_gnt,
                        bus.dbg_gnt, exp_cpu);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic        wr_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ad_t [4] = '{32'd4, 32'd20, 32'd12, 32'd4};
    logic [31:0] ex_t [4] = '{32'h11111111, 32'hDEADBEEF, 32'd5, 32'h11111111};
    for (int i = 0; i < 4; i++) begin
      drive_dbg(1'b1, wr_t[i], ad_t[i], ex_t[i], 1'b0);
      #2;
      total++;
      if (bus.dbg_gnt !== 1'b1) begin
        bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, bus.dbg_gnt);
      end
      tick();
      total++;
      if (bus.dbg_rsp_valid !== !wr_t[i] || (!wr_t[i] && bus.dbg_rdata !== ex_t[i])) begin
        bad++; $display("FAIL b2b_rsp[%0d] got=%b %h exp=%b %h", i, bus.dbg_rsp_valid,
                        bus.dbg_rdata, !wr_t[i], ex_t[i]);
      end
    end
    idle();
    tick();
    total++;
    if (bus.dbg_rsp_valid !== 1'b0 || bus.dbg_rdata !== 32'h11111111) begin
      bad++; $display("FAIL b2b_hold got=%b %h exp=0 11111111", bus.dbg_rsp_valid,
                      bus.dbg_rdata);
    end
  endtask

  task automatic test_reset_mid();
    drive_cpu(1'b1, 1'b0, 32'd20, 32'h0);
    tick();
    total++;
    if (bus.cpu_rsp_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre_rsp got=%b exp=1", bus.cpu_rsp_valid);
    end
    drive_cpu(1'b1, 1'b1, 32'd20, 32'hBAD0BAD0);
    drive_dbg(1'b1, 1'b0, 32'd12, 32'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.cpu_gnt !== 1'b0 ||
        bus.dbg_gnt !== 1'b0 || bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b %h gnt=%b%b we=%b exp=0 0 00 0",
                      bus.cpu_rsp_valid, bus.cpu_rdata, bus.cpu_gnt, bus.dbg_gnt,
                      bus.mem_write);
    end
    tick();
    idle();
    reset_n = 1'b1;
    tick();
    total++;
    if (bus.cpu_rsp_valid !== 1'b0 || bus.dbg_rsp_valid !== 1'b0 || mem[20] !== 32'hDEADBEEF)
    begin
      bad++; $display("FAIL mid_after got=%b%b mem=%h exp=00 deadbeef", bus.cpu_rsp_valid,
                      bus.dbg_rsp_valid, mem[20]);
    end
    drive_cpu(1'b1, 1'b0, 32'd20, 32'h0);
    drive_dbg(1'b1, 1'b0, 32'd12, 32'h0, 1'b0);
    #2;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL mid_first_tie got=%b%b exp=10", bus.cpu_gnt, bus.dbg_gnt);
    end
    tick();
    idle();
    tick();
  endtask

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  task automatic test_misalign();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL mis_initial got=%b exp=0", err);
    end
    drive_cpu(1'b1, 1'b1, 32'd13, 32'h000000AA);
    #2;
    total++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL mis_write got=%b we=%b exp=1 0", bus.cpu_gnt, bus.mem_write);
    end
    tick();
    drive_cpu(1'b1, 1'b0, 32'd13, 32'h0);
    total++;
    if (err !== 1'b1 || mem[13] !== 32'h0) begin
      bad++; $display("FAIL mis_err got=%b mem=%h exp=1 0", err, mem[13]);
    end
    tick();
    idle();
    total++;
    if (bus.cpu_rsp_valid !== 1'b0 || err !== 1'b1) begin
      bad++; $display("FAIL mis_read got=%b err=%b exp=0 1", bus.cpu_rsp_valid, err);
    end
    tick();
    tick();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL mis_sticky got=%b exp=1", err);
    end
    do_reset();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL mis_cleared got=%b exp=0", err);
    end
  endtask
`else
  task automatic test_misalign();
    drive_cpu(1'b1, 1'b1, 32'd13, 32'h000000AA);
    #2;
    total++;
    if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'd13) begin
      bad++; $display("FAIL unaligned_pass we=%b addr=%0d exp=1 13", bus.mem_write,
                      bus.mem_address);
    end
    tick();
    idle();
    total++;
    if (mem[13] !== 32'h000000AA) begin
      bad++; $display("FAIL unaligned_mem got=%h exp=aa", mem[13]);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_write_read();
    test_raw();
    test_alternate();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
